// File: rtl/autosa_sdp_pkg.sv
// Shared definitions for the SDP RDMA gearbox: segment-index sizing, legal ratio
// range and a saturating counter increment.
package autosa_sdp_pkg;

   localparam int RATIO_MIN = 1;
   localparam int RATIO_MAX = 64;
   localparam int SAT_W     = 64;

   // A single-segment gearbox still needs a 1-bit index port.
   function automatic int seg_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val, input int width);
      logic [SAT_W-1:0] top;
      top = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
      return (val >= top) ? val : val + SAT_W'(1);
   endfunction

endpackage

// File: rtl/autosa_sdp_skid2.sv
// Generic 2-entry registered skid buffer: output fully registered, in_rdy comes
// from a flop, so there is no combinational path from out_rdy back to in_rdy.
module autosa_sdp_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_data,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_data
);

   logic         skid_vld;
   logic [W-1:0] skid_data;
   logic         out_load;

   assign in_rdy   = !skid_vld;
   assign out_load = !out_vld || out_rdy;

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values of the others, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (out_load) begin
         out_vld  <= skid_vld || in_vld;
         skid_vld <= 1'b0;
      end else if (in_vld && in_rdy) begin
         skid_vld <= 1'b1;
      end
   end

   // NOTE: payload registers carry no reset; they are only observed when the
   // matching valid flop is set, and leaving them unreset keeps the wide path cheap.
   always_ff @(posedge clk) begin
      if (out_load) begin
         out_data <= skid_vld ? skid_data : in_data;
      end else if (in_vld && in_rdy) begin
         skid_data <= in_data;
      end
   end

endmodule

// File: rtl/autosa_sdp_rdma_gearbox.sv
// Wide-to-narrow unpacker for the SDP RDMA read-return path: one IW-bit word in,
// up to IW/OW segments out (lowest first), with optional registered skid output.
module autosa_sdp_rdma_gearbox
   import autosa_sdp_pkg::*;
#(
   parameter  int IW      = 512,
   parameter  int OW      = 256,
   parameter  int CW      = 1,
   parameter  int OUT_REG = 1,
   parameter  int CNTW    = 32,
   localparam int RATIO   = IW / OW,
   localparam int SEGW    = seg_width(RATIO)
) (
   input  logic            autosa_core_clk,
   input  logic            autosa_core_rstn,
   input  logic [SEGW-1:0] cfg_seg_num,
   input  logic            cfg_cnt_clr,
   input  logic            inp_pvld,
   output logic            inp_prdy,
   input  logic [IW+CW-1:0] inp_data,
   input  logic [SEGW-1:0] inp_nseg,
   output logic            out_pvld,
   input  logic            out_prdy,
   output logic [OW+CW-1:0] out_data,
   output logic            out_last,
   output logic [SEGW-1:0] out_seg_idx,
   output logic [CNTW-1:0] sts_word_cnt,
   output logic [CNTW-1:0] sts_stall_cnt
);

   localparam int              PW      = OW + CW + 1 + SEGW;
   localparam logic [SEGW-1:0] MAX_SEG = SEGW'(RATIO - 1);

   if ((IW % OW) != 0 || RATIO < RATIO_MIN || RATIO > RATIO_MAX || CNTW > SAT_W) begin : g_bad_cfg
      $error("autosa_sdp_rdma_gearbox: illegal IW/OW/CNTW combination");
   end

   logic [IW-1:0]   hold_data;
   logic [CW-1:0]   hold_ctrl;
   logic            hold_vld;
   logic [SEGW-1:0] cnt;
   logic [SEGW-1:0] lim;
   logic            hold_rdy;
   logic            seg_accept;
   logic            inp_accept;
   logic            is_last;
   logic [SEGW-1:0] cfg_clamped;
   logic [SEGW-1:0] new_lim;
   logic [OW-1:0]   seg_data;
   logic [CW-1:0]   ctrl_end;
   logic [PW-1:0]   pkt;
   logic [PW-1:0]   out_pkt;

   // NOTE: every always_comb output gets a default before any condition so no
   // path through the block leaves a value unassigned and infers a latch.
   always_comb begin
      cfg_clamped = cfg_seg_num;
      if (int'(cfg_seg_num) > RATIO - 1) cfg_clamped = MAX_SEG;
      new_lim = (inp_nseg < cfg_clamped) ? inp_nseg : cfg_clamped;
   end

   assign is_last    = (cnt == lim);
   assign seg_accept = hold_vld && hold_rdy;
   assign inp_prdy   = !hold_vld || (seg_accept && is_last);
   assign inp_accept = inp_pvld && inp_prdy;

   assign seg_data = OW'(hold_data >> (OW * int'(cnt)));
   assign ctrl_end = is_last ? hold_ctrl : '0;
   assign pkt      = {ctrl_end, seg_data, is_last, cnt};

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         hold_vld <= 1'b0;
         cnt      <= '0;
         lim      <= '0;
      end else begin
         if (seg_accept) cnt <= is_last ? '0 : cnt + SEGW'(1);
         // The limit is frozen per word, so cfg changes only affect the next word.
         if (inp_accept) begin
            hold_vld <= 1'b1;
            lim      <= new_lim;
         end else if (seg_accept && is_last) begin
            hold_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge autosa_core_clk) begin
      if (inp_accept) begin
         hold_data <= inp_data[IW-1:0];
         hold_ctrl <= inp_data[IW +: CW];
      end
   end

   if (OUT_REG != 0) begin : g_skid
      autosa_sdp_skid2 #(.W(PW)) u_skid (
         .clk      (autosa_core_clk),
         .rst_n    (autosa_core_rstn),
         .in_vld   (hold_vld),
         .in_rdy   (hold_rdy),
         .in_data  (pkt),
         .out_vld  (out_pvld),
         .out_rdy  (out_prdy),
         .out_data (out_pkt)
      );
   end else begin : g_comb
      assign hold_rdy = out_prdy;
      assign out_pvld = hold_vld;
      assign out_pkt  = pkt;
   end

   assign {out_data, out_last, out_seg_idx} = out_pkt;

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         sts_word_cnt  <= '0;
         sts_stall_cnt <= '0;
      end else if (cfg_cnt_clr) begin
         sts_word_cnt  <= '0;
         sts_stall_cnt <= '0;
      end else begin
         if (inp_accept) sts_word_cnt <= CNTW'(sat_inc(SAT_W'(sts_word_cnt), CNTW));
         if (out_pvld && !out_prdy) sts_stall_cnt <= CNTW'(sat_inc(SAT_W'(sts_stall_cnt), CNTW));
      end
   end

endmodule

// File: tb/tb_autosa_sdp_rdma_gearbox.sv
// Scoreboard bench: three gearbox instances (registered 4:1, combinational 4:1,
// registered 3:1) driven with directed and random words against a segment-list model.
module tb_autosa_sdp_rdma_gearbox;

   localparam int IW     = 128;
   localparam int OW     = 32;
   localparam int CW     = 1;
   localparam int CNTW   = 8;
   localparam int SEGW   = 2;
   localparam int NDUT   = 3;
   localparam int BUDGET = 200;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   typedef struct packed {
      logic [OW-1:0]   data;
      logic [CW-1:0]   ctrl;
      logic            last;
      logic [SEGW-1:0] idx;
   } seg_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0] inp_pvld = '0;
   logic [NDUT-1:0] inp_prdy;
   logic [NDUT-1:0] out_pvld;
   logic [NDUT-1:0] out_prdy = '1;
   logic [NDUT-1:0] out_last;
   logic [NDUT-1:0] cfg_cnt_clr = '0;
   logic [NDUT-1:0] prdy_rand = '0;
   logic [SEGW-1:0] cfg_seg_num [NDUT];
   logic [SEGW-1:0] inp_nseg    [NDUT];
   logic [IW+CW-1:0] inp_data   [NDUT];
   logic [OW+CW-1:0] out_data   [NDUT];
   logic [SEGW-1:0] out_seg_idx [NDUT];
   logic [CNTW-1:0] sts_word_cnt  [NDUT];
   logic [CNTW-1:0] sts_stall_cnt [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int GIW = (g == 2) ? 96 : 128;
      localparam int GOR = (g == 1) ? 0 : 1;
      autosa_sdp_rdma_gearbox #(.IW(GIW), .OW(OW), .CW(CW), .OUT_REG(GOR), .CNTW(CNTW)) u_dut (
         .autosa_core_clk  (clk),
         .autosa_core_rstn (rstn),
         .cfg_seg_num      (cfg_seg_num[g]),
         .cfg_cnt_clr      (cfg_cnt_clr[g]),
         .inp_pvld         (inp_pvld[g]),
         .inp_prdy         (inp_prdy[g]),
         .inp_data         ({inp_data[g][IW +: CW], inp_data[g][GIW-1:0]}),
         .inp_nseg         (inp_nseg[g]),
         .out_pvld         (out_pvld[g]),
         .out_prdy         (out_prdy[g]),
         .out_data         (out_data[g]),
         .out_last         (out_last[g]),
         .out_seg_idx      (out_seg_idx[g]),
         .sts_word_cnt     (sts_word_cnt[g]),
         .sts_stall_cnt    (sts_stall_cnt[g])
      );
   end

   function automatic int ratio_of(input int d);
      return (d == 2) ? 3 : 4;
   endfunction

   function automatic int sat(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < NDUT; d++)
            out_prdy[d] = prdy_rand[d] ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   end

   // Reference model state: expected segments per instance, word/stall counts.
   seg_t exp_q [NDUT][$];
   int   m_word  [NDUT];
   int   m_stall [NDUT];
   int   run_len [NDUT];
   int   max_run [NDUT];
   logic [NDUT-1:0] held = '0;
   seg_t held_seg [NDUT];

   task automatic push_word(input int d);
      logic [IW-1:0] w;
      logic [CW-1:0] c;
      int lim;
      w   = inp_data[d][IW-1:0];
      c   = inp_data[d][IW +: CW];
      lim = int'(inp_nseg[d]);
      if (int'(cfg_seg_num[d]) < lim) lim = int'(cfg_seg_num[d]);
      if (ratio_of(d) - 1 < lim) lim = ratio_of(d) - 1;
      for (int k = 0; k <= lim; k++)
         exp_q[d].push_back('{data: w[k*OW +: OW], ctrl: (k == lim) ? c : '0,
                              last: (k == lim), idx: SEGW'(k)});
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         for (int d = 0; d < NDUT; d++) begin
            exp_q[d].delete();
            m_word[d]  = 0;
            m_stall[d] = 0;
            run_len[d] = 0;
            held[d]    = 1'b0;
         end
      end else begin
         for (int d = 0; d < NDUT; d++) begin
            seg_t got;
            seg_t want;
            got = '{data: out_data[d][OW-1:0], ctrl: out_data[d][OW +: CW],
                    last: out_last[d], idx: out_seg_idx[d]};
            if (held[d]) begin
               check("stall_keeps_valid", 64'(out_pvld[d]), 64'd1);
               check("stall_keeps_payload", 64'(got), 64'(held_seg[d]));
            end
            if (inp_pvld[d] && inp_prdy[d]) push_word(d);
            if (out_pvld[d]) begin
               run_len[d]++;
               if (run_len[d] > max_run[d]) max_run[d] = run_len[d];
            end else begin
               run_len[d] = 0;
            end
            if (out_pvld[d] && out_prdy[d]) begin
               check("segment_expected", 64'(exp_q[d].size() != 0), 64'd1);
               if (exp_q[d].size() != 0) begin
                  want = exp_q[d].pop_front();
                  check("segment", 64'(got), 64'(want));
               end
            end
            held[d]     = out_pvld[d] && !out_prdy[d];
            held_seg[d] = got;
            if (cfg_cnt_clr[d]) begin
               m_word[d]  = 0;
               m_stall[d] = 0;
            end else begin
               if (inp_pvld[d] && inp_prdy[d]) m_word[d] = sat(m_word[d]);
               if (out_pvld[d] && !out_prdy[d]) m_stall[d] = sat(m_stall[d]);
            end
         end
      end
   end

   // acc is the index of the cycle in which the handshake was seen.
   task automatic send(input int d, input logic [IW-1:0] data, input logic [CW-1:0] ctrl,
                       input logic [SEGW-1:0] nseg, output int acc);
      int n;
      bit ok;
      n   = 0;
      ok  = 1'b0;
      acc = 0;
      inp_pvld[d] = 1'b1;
      inp_data[d] = {ctrl, data};
      inp_nseg[d] = nseg;
      while (!ok && n < BUDGET) begin
         @(negedge clk);
         ok  = inp_prdy[d];
         acc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      inp_pvld[d] = 1'b0;
      check("send_accepted", 64'(ok), 64'd1);
   endtask

   task automatic wait_valid(input int d, output int at);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      at   = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = out_pvld[d];
         at   = cyc;
         n++;
      end
      check("valid_seen", 64'(seen), 64'd1);
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (exp_q[d].size() != 0 && n < 4000);
      repeat (3) @(posedge clk);
      #1;
      check("drained", 64'(exp_q[d].size()), 64'd0);
   endtask

   task automatic pulse_clr(input int d);
      cfg_cnt_clr[d] = 1'b1;
      @(posedge clk);
      #1;
      cfg_cnt_clr[d] = 1'b0;
   endtask

   function automatic logic [IW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   localparam logic [IW-1:0] WORD1 = 128'h44444444_33333333_22222222_11111111;

   initial begin
      int a, b, at;
      for (int d = 0; d < NDUT; d++) begin
         cfg_seg_num[d] = 2'd3;
         inp_nseg[d]    = 2'd3;
         inp_data[d]    = '0;
         max_run[d]     = 0;
      end
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check("reset_out_pvld", 64'(out_pvld[d]), 64'd0);
         check("reset_inp_prdy", 64'(inp_prdy[d]), 64'd1);
         check("reset_word_cnt", 64'(sts_word_cnt[d]), 64'd0);
         check("reset_stall_cnt", 64'(sts_stall_cnt[d]), 64'd0);
      end

      // Full 4-segment word; first-segment latency per output style.
      send(0, WORD1, 1'b1, 2'd3, a);
      wait_valid(0, at);
      check("latency_out_reg1", 64'(at - a), 64'd2);
      drain(0);
      send(1, WORD1, 1'b1, 2'd3, a);
      wait_valid(1, at);
      check("latency_out_reg0", 64'(at - a), 64'd1);
      drain(1);

      // Two-segment word, cfg changed before the next word, back-to-back accept.
      cfg_seg_num[0] = 2'd1;
      send(0, WORD1, 1'b1, 2'd3, a);
      cfg_seg_num[0] = 2'd3;
      send(0, ~WORD1, 1'b1, 2'd3, b);
      check("back_to_back_gap", 64'(b - a), 64'd2);
      drain(0);

      // 3:1 instance: cfg 3 clamps to 3 segments.
      send(2, WORD1, 1'b1, 2'd3, a);
      send(2, WORD1, 1'b0, 2'd3, b);
      check("clamp_gap", 64'(b - a), 64'd3);
      drain(2);

      // Clear wins over an accept in the same cycle, then a one-segment word.
      cfg_cnt_clr[0] = 1'b1;
      send(0, WORD1, 1'b1, 2'd3, a);
      cfg_cnt_clr[0] = 1'b0;
      check("clear_priority", 64'(sts_word_cnt[0]), 64'd0);
      drain(0);
      send(0, WORD1, 1'b1, 2'd0, a);
      drain(0);
      check("word_cnt_single", 64'(sts_word_cnt[0]), 64'd1);

      // Sustained full words with out_prdy=1: gapless output stream.
      for (int d = 0; d < NDUT; d++) begin
         cfg_seg_num[d] = 2'd3;
         pulse_clr(d);
         max_run[d] = 0;
         for (int i = 0; i < 100; i++) send(d, rand_word(), 1'($urandom), 2'd3, a);
         drain(d);
         check("gapless_run", 64'(max_run[d]), 64'(100 * ratio_of(d)));
         check("word_cnt_100", 64'(sts_word_cnt[d]), 64'd100);
         check("stall_cnt_zero", 64'(sts_stall_cnt[d]), 64'd0);
      end

      // Random words, trims, cfg and backpressure.
      for (int d = 0; d < NDUT; d++) begin
         pulse_clr(d);
         prdy_rand[d] = 1'b1;
         for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            cfg_seg_num[d] = SEGW'($urandom_range(0, 3));
            send(d, rand_word(), 1'($urandom), SEGW'($urandom_range(0, 3)), a);
            if (i == 15) check("stall_cnt_partial", 64'(sts_stall_cnt[d]), 64'(m_stall[d]));
         end
         prdy_rand[d] = 1'b0;
         drain(d);
         check("word_cnt_random", 64'(sts_word_cnt[d]), 64'd100);
         check("stall_cnt_random", 64'(sts_stall_cnt[d]), 64'(m_stall[d]));
      end

      // Reset after segment 1 of a word; the next word restarts at segment 0.
      cfg_seg_num[0] = 2'd3;
      send(0, WORD1, 1'b1, 2'd3, a);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(out_pvld[0] && out_seg_idx[0] == 2'd1) && n < 20);
         check("reached_segment1", 64'(out_seg_idx[0]), 64'd1);
      end
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("midword_reset_out_pvld", 64'(out_pvld[0]), 64'd0);
      check("midword_reset_inp_prdy", 64'(inp_prdy[0]), 64'd1);
      check("midword_reset_word_cnt", 64'(sts_word_cnt[0]), 64'd0);
      check("midword_reset_stall_cnt", 64'(sts_stall_cnt[0]), 64'd0);
      @(posedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      send(0, ~WORD1, 1'b1, 2'd3, a);
      wait_valid(0, at);
      check("restart_seg_idx", 64'(out_seg_idx[0]), 64'd0);
      drain(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
